// File: rtl/ak4619_pkg.sv
// Shared constants for the AK4619 configuration sequencer: I2C command encoding, codec defaults, FSM states.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package ak4619_pkg;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    localparam logic [6:0] AK4619_DEV_ADDR = 7'h10;
    localparam int         AK4619_NUM_REGS = 21;

    typedef logic [3:0] state_t;

    localparam state_t S_PDN_LOW   = 4'd0;
    localparam state_t S_SETTLE    = 4'd1;
    localparam state_t S_I2C_START = 4'd2;
    localparam state_t S_DEV       = 4'd3;
    localparam state_t S_REG       = 4'd4;
    localparam state_t S_DATA      = 4'd5;
    localparam state_t S_I2C_STOP  = 4'd6;
    localparam state_t S_DONE      = 4'd7;
    localparam state_t S_ERR       = 4'd8;
    localparam state_t S_GAP       = 4'd9;
    localparam state_t S_RSTART    = 4'd10;
    localparam state_t S_DEVR      = 4'd11;
    localparam state_t S_READ      = 4'd12;

endpackage

// File: rtl/ak4619_cfg_rom.sv
// AK4619 register image, indexed from register 0x00; the only home of the codec register values.
// Latency: combinational.
// Backpressure: none.
module ak4619_cfg_rom #(
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [7:0]       o_dat
);

    always_comb begin
        o_dat = 8'h00;
        case (int'(i_idx))
            0:  o_dat = 8'h37;
            1:  o_dat = 8'hAE;
            2:  o_dat = 8'h1C;
            3:  o_dat = 8'h00;
            4:  o_dat = 8'h22;
            5:  o_dat = 8'h22;
            6:  o_dat = 8'h30;
            7:  o_dat = 8'h30;
            8:  o_dat = 8'h30;
            9:  o_dat = 8'h30;
            10: o_dat = 8'h22;
            11: o_dat = 8'h00;
            12: o_dat = 8'h00;
            13: o_dat = 8'h00;
            14: o_dat = 8'h18;
            15: o_dat = 8'h18;
            16: o_dat = 8'h18;
            17: o_dat = 8'h18;
            18: o_dat = 8'h04;
            19: o_dat = 8'h05;
            20: o_dat = 8'h0A;
            default: o_dat = 8'h00;
        endcase
    end

endmodule

// File: rtl/ak4619_cfg_seq.sv
// AK4619 power-up (PDN) and register-burst sequencer over a byte-level I2C master; AK4619_CFG_VERIFY_EN adds read-back.
// Latency: PDN_WAIT + PDN_SETTLE cycles before the first START, then one command per master response.
// Backpressure: each command is held until cmd_ready; only one command outstanding, next waits for rsp_valid.
module ak4619_cfg_seq
    import ak4619_pkg::*;
#(
    parameter int         CLK_HZ      = 12000000,
    parameter logic [6:0] DEV_ADDR    = AK4619_DEV_ADDR,
    parameter int         NUM_REGS    = AK4619_NUM_REGS,
    parameter int         PDN_WAIT    = 12000,
    parameter int         PDN_SETTLE  = 120000,
    parameter int         MAX_RETRIES = 3,
    parameter int         RETRY_GAP   = 1200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       pdn,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_data,
    output logic       cmd_nack_last,
    input  logic       rsp_valid,
    input  logic       rsp_nack,
    input  logic [7:0] rsp_data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int IDX_W   = $clog2(NUM_REGS + 1);
    localparam int CNT_MAX = (PDN_SETTLE > PDN_WAIT) ?
                             ((PDN_SETTLE > RETRY_GAP) ? PDN_SETTLE : RETRY_GAP) :
                             ((PDN_WAIT > RETRY_GAP) ? PDN_WAIT : RETRY_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]   WAIT_LAST  = CNT_W'(PDN_WAIT - 1);
    localparam logic [CNT_W-1:0]   SETL_LAST  = CNT_W'(PDN_SETTLE - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(RETRY_GAP - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [RETRY_W-1:0] r_retry;
    logic               r_pdn;
    logic               r_cmd_valid;
    logic               r_rsp_wait;
    logic               r_nacked;
`ifdef AK4619_CFG_VERIFY_EN
    logic               r_verify;
    logic               r_mismatch;
`endif

    logic [7:0] w_rom_dat;
    logic [1:0] w_op;
    logic [7:0] w_dat;
    logic       w_unused;

    ak4619_cfg_rom #(.IDX_W(IDX_W)) u_rom (
        .i_idx (r_idx),
        .o_dat (w_rom_dat)
    );

    // Command op/byte are a pure function of state and idx, so they cannot move while cmd_valid waits.
    always_comb begin
        w_op  = OP_STOP;
        w_dat = 8'h00;
        case (r_state)
            S_I2C_START, S_RSTART: w_op = OP_START;
            S_DEV:  begin w_op = OP_WRITE; w_dat = {DEV_ADDR, 1'b0}; end
            S_REG:  w_op = OP_WRITE;
            S_DATA: begin w_op = OP_WRITE; w_dat = w_rom_dat; end
            S_DEVR: begin w_op = OP_WRITE; w_dat = {DEV_ADDR, 1'b1}; end
            S_READ: w_op = OP_READ;
            default: w_op = OP_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_PDN_LOW;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_retry     <= '0;
            r_pdn       <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_rsp_wait  <= 1'b0;
            r_nacked    <= 1'b0;
`ifdef AK4619_CFG_VERIFY_EN
            r_verify    <= 1'b0;
            r_mismatch  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_PDN_LOW: begin
                    if (r_cnt == WAIT_LAST) begin
                        r_cnt   <= '0;
                        r_pdn   <= 1'b1;
                        r_state <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETL_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_I2C_START;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_I2C_START;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        r_state  <= S_PDN_LOW;
                        r_pdn    <= 1'b0;
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_retry  <= '0;
                        r_nacked <= 1'b0;
`ifdef AK4619_CFG_VERIFY_EN
                        r_verify   <= 1'b0;
                        r_mismatch <= 1'b0;
`endif
                    end
                end
                default: begin
                    if (!r_cmd_valid && !r_rsp_wait) begin
                        r_cmd_valid <= 1'b1;
                    end else if (r_cmd_valid && cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_rsp_wait  <= 1'b1;
                    end else if (r_rsp_wait && rsp_valid) begin
                        r_rsp_wait <= 1'b0;
                        if (w_op == OP_WRITE && rsp_nack) begin
                            r_nacked <= 1'b1;
                            r_state  <= S_I2C_STOP;
                        end else begin
                            case (r_state)
                                S_I2C_START: r_state <= S_DEV;
                                S_DEV:       r_state <= S_REG;
                                S_REG: begin
                                    r_idx <= '0;
`ifdef AK4619_CFG_VERIFY_EN
                                    r_state <= r_verify ? S_RSTART : S_DATA;
`else
                                    r_state <= S_DATA;
`endif
                                end
                                S_DATA: begin
                                    if (r_idx == LAST_IDX) r_state <= S_I2C_STOP;
                                    else                   r_idx   <= r_idx + IDX_W'(1);
                                end
                                S_I2C_STOP: begin
                                    if (r_nacked) begin
                                        if (r_retry == RETRY_LAST) begin
                                            r_state <= S_ERR;
                                        end else begin
                                            r_retry  <= r_retry + RETRY_W'(1);
                                            r_nacked <= 1'b0;
                                            r_idx    <= '0;
                                            r_cnt    <= '0;
                                            r_state  <= S_GAP;
`ifdef AK4619_CFG_VERIFY_EN
                                            r_verify   <= 1'b0;
                                            r_mismatch <= 1'b0;
`endif
                                        end
                                    end
`ifdef AK4619_CFG_VERIFY_EN
                                    else if (!r_verify) begin
                                        r_verify <= 1'b1;
                                        r_idx    <= '0;
                                        r_state  <= S_I2C_START;
                                    end else begin
                                        r_state <= r_mismatch ? S_ERR : S_DONE;
                                    end
`else
                                    else begin
                                        r_state <= S_DONE;
                                    end
`endif
                                end
`ifdef AK4619_CFG_VERIFY_EN
                                S_RSTART: r_state <= S_DEVR;
                                S_DEVR: begin
                                    r_idx   <= '0;
                                    r_state <= S_READ;
                                end
                                S_READ: begin
                                    if (rsp_data != w_rom_dat) r_mismatch <= 1'b1;
                                    if (r_idx == LAST_IDX) r_state <= S_I2C_STOP;
                                    else                   r_idx   <= r_idx + IDX_W'(1);
                                end
`endif
                                default: r_state <= S_ERR;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign pdn       = r_pdn;
    assign cmd_valid = r_cmd_valid;
    assign cmd_op    = r_cmd_valid ? w_op : OP_START;
    assign cmd_data  = r_cmd_valid ? w_dat : 8'h00;
    assign busy      = (r_state != S_DONE) && (r_state != S_ERR);
    assign done      = (r_state == S_DONE);
    assign error     = (r_state == S_ERR);
`ifdef AK4619_CFG_VERIFY_EN
    assign cmd_nack_last = r_cmd_valid && (r_state == S_READ) && (r_idx == LAST_IDX);
`else
    assign cmd_nack_last = 1'b0;
`endif

    // Read data only matters for verify; CLK_HZ is informational.
    assign w_unused = (^rsp_data) ^ (CLK_HZ == 0);

endmodule

// File: tb/tb_ak4619_cfg_seq.sv
// Bench for ak4619_cfg_seq: behavioural I2C master plus a command scoreboard fed by the stimulus process.
`timescale 1ns/1ps
module tb_ak4619_cfg_seq;
    import ak4619_pkg::*;

    localparam int PW   = 20;
    localparam int PS   = 40;
    localparam int RG   = 30;
    localparam int NREG = 21;
`ifdef AK4619_CFG_VERIFY_EN
    localparam int VSTARTS = 2;
`else
    localparam int VSTARTS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, start, pdn, cmd_valid, cmd_ready, cmd_nack_last;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data, rsp_data;
    logic       rsp_valid, rsp_nack, busy, done, error;

    always #5 clk = ~clk;

    ak4619_cfg_seq #(
        .CLK_HZ(12000000), .DEV_ADDR(7'h10), .NUM_REGS(NREG), .PDN_WAIT(PW),
        .PDN_SETTLE(PS), .MAX_RETRIES(3), .RETRY_GAP(RG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pdn(pdn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_nack_last(cmd_nack_last),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_data(rsp_data),
        .busy(busy), .done(done), .error(error)
    );

    logic [7:0] rom_tb [NREG] = '{8'h37, 8'hAE, 8'h1C, 8'h00, 8'h22, 8'h22, 8'h30, 8'h30,
                                  8'h30, 8'h30, 8'h22, 8'h00, 8'h00, 8'h00, 8'h18, 8'h18,
                                  8'h18, 8'h18, 8'h04, 8'h05, 8'h0A};

    int tests = 0;
    int fails = 0;
    logic [10:0] exp_q [$];

    int nack_dev = 0, stall_left = 0, stall_seen = 0, hold_at_wr = -1, bad_idx = -1;
    int wr_cnt = 0, rd_idx = 0;
    bit pend = 0, pend_nack = 0, prev_dev = 0;
    logic [7:0] pend_data = 8'h00;

    int start_cnt = 0, idle = 0, gap_checks = 0;
    bit gap_armed = 0, burst_nacked = 0, prev_acc = 0, prev_stall = 0;
    logic [10:0] prev_cmd = '0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] d, input logic nl);
        exp_q.push_back({nl, op, d});
    endtask

    task automatic push_nack_burst();
        push(OP_START, 8'h00, 1'b0);
        push(OP_WRITE, 8'h20, 1'b0);
        push(OP_STOP, 8'h00, 1'b0);
    endtask

    task automatic push_good();
        push(OP_START, 8'h00, 1'b0);
        push(OP_WRITE, 8'h20, 1'b0);
        push(OP_WRITE, 8'h00, 1'b0);
        for (int i = 0; i < NREG; i++) push(OP_WRITE, rom_tb[i], 1'b0);
        push(OP_STOP, 8'h00, 1'b0);
`ifdef AK4619_CFG_VERIFY_EN
        push(OP_START, 8'h00, 1'b0);
        push(OP_WRITE, 8'h20, 1'b0);
        push(OP_WRITE, 8'h00, 1'b0);
        push(OP_START, 8'h00, 1'b0);
        push(OP_WRITE, 8'h21, 1'b0);
        for (int i = 0; i < NREG; i++) push(OP_READ, 8'h00, (i == NREG - 1));
        push(OP_STOP, 8'h00, 1'b0);
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!(done || error) && n < 20000) begin @(negedge clk); n++; end
        chk({name, "_timeout"}, int'(n >= 20000), 0);
    endtask

    task automatic wait_pdn_rise(input string name);
        int n = 0;
        while (!pdn && n < 5000) begin @(negedge clk); n++; end
        chk({name, "_pdn_rise_cycle"}, n, PW);
    endtask

    // Behavioural I2C master: decides ready at each falling edge, answers one cycle after acceptance.
    initial begin
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
        forever begin
            bit rdy;
            @(negedge clk);
            rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
            if (!rst_n) begin pend = 0; cmd_ready = 1'b0; continue; end
            if (pend) begin
                rsp_valid = 1'b1; rsp_nack = pend_nack; rsp_data = pend_data; pend = 0;
            end
            rdy = 1;
            if (cmd_valid && cmd_op == OP_WRITE) begin
                if (wr_cnt == hold_at_wr) rdy = 0;
                else if (stall_left > 0 && prev_dev && cmd_data == 8'h00) begin
                    rdy = 0; stall_left--; stall_seen++;
                end
            end
            cmd_ready = rdy;
            if (cmd_valid && rdy) begin
                pend = 1; pend_nack = 0; pend_data = 8'h00;
                case (cmd_op)
                    OP_START: begin wr_cnt = 0; rd_idx = 0; prev_dev = 0; end
                    OP_WRITE: begin
                        if (cmd_data == 8'h20 && nack_dev > 0) begin pend_nack = 1; nack_dev--; end
                        prev_dev = (cmd_data == 8'h20);
                        wr_cnt++;
                    end
                    OP_READ: begin
                        pend_data = (rd_idx == bad_idx) ? 8'hFF : rom_tb[rd_idx];
                        rd_idx++; prev_dev = 0;
                    end
                    default: prev_dev = 0;
                endcase
            end
        end
    end

    // Monitor: scoreboard pops on every acceptance, plus handshake and retry-gap checks.
    initial begin
        forever begin
            bit acc;
            logic [10:0] cur;
            @(negedge clk); #2;
            if (!rst_n) begin prev_acc = 0; prev_stall = 0; gap_armed = 0; burst_nacked = 0; continue; end
            cur = {cmd_nack_last, cmd_op, cmd_data};
            if (!pdn) gap_armed = 0;
            if (prev_acc) chk("vld_drop_after_accept", cmd_valid, 0);
            if (prev_stall) begin
                chk("stall_vld_held", cmd_valid, 1);
                chk("stall_cmd_stable", cur, prev_cmd);
            end
            if (rsp_valid && rsp_nack) burst_nacked = 1;
            if (!cmd_valid && !rsp_valid) idle++;
            acc = cmd_valid && cmd_ready;
            if (acc) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL cmd_unexpected: got 0x%0h with nothing expected", cur);
                end else begin
                    chk("cmd", cur, exp_q.pop_front());
                end
                if (cmd_op == OP_START) begin
                    start_cnt++;
                    if (gap_armed) begin chk_rng("retry_gap_idle", idle, RG, RG + 2); gap_checks++; gap_armed = 0; end
                end
                if (cmd_op == OP_STOP) begin gap_armed = burst_nacked; burst_nacked = 0; idle = 0; end
            end
            prev_acc = acc;
            prev_stall = cmd_valid && !cmd_ready;
            prev_cmd = cur;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values and the ideal-master burst
        chk("rst_pdn", pdn, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_op", cmd_op, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_nack_last", cmd_nack_last, 0);
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        push_good();
        start_cnt = 0;
        rst_n = 1'b1;
        wait_pdn_rise("t1");
        n = 0;
        while (!cmd_valid && n < 5000) begin @(negedge clk); n++; end
        chk_rng("t1_first_start_cycle", n, PS, PS + 2);
        wait_end("t1");
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_error", error, 0);
        chk("t1_starts", start_cnt, 1 + VSTARTS);
        chk("t1_queue_left", exp_q.size(), 0);

        // REG byte stalled 5 cycles by the master
        push_good();
        stall_left = 5; stall_seen = 0;
        pulse_start();
        chk("t2_pdn_low", pdn, 0);
        chk("t2_busy", busy, 1);
        chk("t2_done_clr", done, 0);
        wait_end("t2");
        chk("t2_stall_cycles", stall_seen, 5);
        chk("t2_done", done, 1);
        chk("t2_queue_left", exp_q.size(), 0);

        // Two NACKed attempts, third succeeds
        nack_dev = 2; gap_checks = 0; start_cnt = 0;
        push_nack_burst(); push_nack_burst(); push_good();
        pulse_start();
        wait_end("t3");
        chk("t3_done", done, 1);
        chk("t3_error", error, 0);
        chk("t3_starts", start_cnt, 3 + VSTARTS);
        chk("t3_gap_checks", gap_checks, 2);
        chk("t3_queue_left", exp_q.size(), 0);

        // NACK forever: 1 + 3 retries, then error
        nack_dev = 1000; start_cnt = 0;
        repeat (4) push_nack_burst();
        pulse_start();
        wait_end("t4");
        chk("t4_error", error, 1);
        chk("t4_done", done, 0);
        chk("t4_busy", busy, 0);
        chk("t4_starts", start_cnt, 4);
        chk("t4_queue_left", exp_q.size(), 0);
        nack_dev = 0;

        // Restart from error, then reset while DATA idx 7 is presented
        hold_at_wr = 9;
        push_good();
        pulse_start();
        chk("t4_restart_pdn", pdn, 0);
        chk("t4_restart_busy", busy, 1);
        chk("t4_restart_error", error, 0);
        n = 0;
        while (!(cmd_valid && wr_cnt == 9) && n < 5000) begin @(negedge clk); n++; end
        chk("t5_hold_timeout", int'(n >= 5000), 0);
        chk("t5_data_idx7", cmd_data, rom_tb[7]);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_cmd_valid", cmd_valid, 0);
        chk("t5_async_pdn", pdn, 0);
        chk("t5_async_done", done, 0);
        chk("t5_async_busy", busy, 1);
        hold_at_wr = -1;
        exp_q.delete();
        push_good();
        start_cnt = 0;
        @(negedge clk); rst_n = 1'b1;
        wait_pdn_rise("t5");
        wait_end("t5");
        chk("t5_done", done, 1);
        chk("t5_starts", start_cnt, 1 + VSTARTS);
        chk("t5_queue_left", exp_q.size(), 0);

`ifdef AK4619_CFG_VERIFY_EN
        // Read-back mismatch at idx 3: reads finish, STOP, error, no retry
        bad_idx = 3; start_cnt = 0;
        push_good();
        pulse_start();
        wait_end("t6");
        chk("t6_error", error, 1);
        chk("t6_done", done, 0);
        chk("t6_busy", busy, 0);
        chk("t6_starts", start_cnt, 3);
        chk("t6_queue_left", exp_q.size(), 0);
        bad_idx = -1;
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ak4619_cfg_seq.md
Name: ak4619_cfg_seq

Overview:
Power-up and register-configuration sequencer for the AK4619 codec. Owns the codec PDN pin, waits out the power-up delay, then burst-writes the codec register image over a byte-level I2C master via a command/response handshake. Retries on NACK and reports done or error. Sits between the top level and the I2C master, replacing the free-running init that is clocked from LRCK.

Parameters:
- CLK_HZ, 12000000, system clock frequency; documentation only.
- DEV_ADDR, 7'h10, codec 7-bit I2C address.
- NUM_REGS, 21, registers written, starting at 0x00 with auto-increment.
- PDN_WAIT, 12000, clk cycles PDN is held low after reset or start (1 ms).
- PDN_SETTLE, 120000, clk cycles after PDN rises before the first I2C command (10 ms).
- MAX_RETRIES, 3, NACK retries before error.
- RETRY_GAP, 1200, idle clk cycles between a failed burst's STOP and the next START.

Ports:
- clk  in  1  system clock (12 MHz).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; restarts the full PDN and configuration sequence.
- pdn  out  1  codec power-down pin; low = powered down.
- cmd_valid  out  1  command to the I2C master is valid.
- cmd_ready  in  1  I2C master accepts the command.
- cmd_op  out  2  0 START, 1 WRITE, 2 READ, 3 STOP.
- cmd_data  out  8  byte for WRITE; 0 otherwise.
- cmd_nack_last  out  1  READ only: master sends NACK after this byte.
- rsp_valid  in  1  one-cycle response for the previously accepted command.
- rsp_nack  in  1  WRITE response: slave NACKed.
- rsp_data  in  8  READ response byte.
- busy  out  1  sequence in progress.
- done  out  1  level; configuration succeeded.
- error  out  1  level; retries exhausted, or a verify mismatch.

Behaviour:
- Reset values: pdn=0, cmd_valid=0, cmd_op=0, cmd_data=0, cmd_nack_last=0, busy=1, done=0, error=0. The FSM enters PDN_LOW.
- Reset asserted mid-transfer: all outputs return to reset values immediately. The I2C master shares rst_n.
- States:
  - PDN_LOW: count PDN_WAIT cycles, then set pdn=1 and go to SETTLE.
  - SETTLE: count PDN_SETTLE cycles, then go to I2C_START.
  - I2C_START: issue START.
  - DEV: WRITE byte {DEV_ADDR,1'b0}.
  - REG: WRITE byte 0x00.
  - DATA: WRITE rom[idx] for idx 0..NUM_REGS-1.
  - I2C_STOP: issue STOP, then go to DONE.
  - DONE: done=1, busy=0.
  - ERR: error=1, busy=0.
- Command handshake:
  - Each command state raises cmd_valid with op and data stable until the cycle cmd_valid&&cmd_ready.
  - In the cycle after acceptance, cmd_valid=0. The FSM then waits for rsp_valid, arriving at least one cycle after acceptance.
  - Exactly one command is outstanding at a time.
- NACK on any WRITE response: issue STOP, increment retry_cnt, idle RETRY_GAP cycles, then restart at I2C_START with idx=0.
  - If retry_cnt is already MAX_RETRIES, go to ERR after the STOP response instead.
  - retry_cnt clears on start and on reset.
- start pulse:
  - From DONE or ERR: clear done and error, set busy, pdn=0, enter PDN_LOW.
  - While busy: ignored, no effect mid-transaction.
- idx is $clog2(NUM_REGS+1) bits wide. The DATA→I2C_STOP transition happens when idx==NUM_REGS-1 and the response is an ACK. idx never wraps.

Optional Feature:
Macro: AK4619_CFG_VERIFY_EN.
- Defined: after the write burst's STOP, read back and compare.
  - Command sequence: START, WRITE {DEV_ADDR,0}, WRITE 0x00, START (repeated start), WRITE {DEV_ADDR,1}, then NUM_REGS READs with cmd_nack_last=1 on the last, then STOP.
  - Each rsp_data is compared with rom[idx].
  - On the first mismatch, finish the reads and STOP, then go to ERR. A mismatch does not consume retries; a NACK during verify does.
  - DONE is entered only if every byte matches.
- Undefined: the READ op is never issued, cmd_nack_last is tied 0, and DONE follows the write STOP.

Decomposition:
- Package ak4619_pkg holds:
  - the cmd_op encoding constants (OP_START, OP_WRITE, OP_READ, OP_STOP);
  - AK4619_DEV_ADDR default;
  - AK4619_NUM_REGS;
  - the FSM state typedef.
- Sub-module ak4619_cfg_rom: combinational, address idx, output 8-bit register image. This is the only place register values live.

Test Plan:
- Reset release, ideal master (ready=1, ACK, response 1 cycle later) → pdn rises at cycle 12000. First START accepted after 120000 more cycles. Bytes observed: 0x20, 0x00, then 21 rom bytes, then STOP. done=1, busy=0, error=0.
- Master holds cmd_ready low 5 cycles on the REG command → cmd_valid, cmd_op and cmd_data stay stable all 5 cycles. Exactly one acceptance.
- NACK on DEV byte on the first two attempts, ACK on the third → two STOPs, each followed by 1200 idle cycles. Third burst completes and done=1.
- NACK on DEV byte every attempt → 4 STARTs total (1+3 retries), then error=1, done=0, busy=0. A start pulse then drives pdn low and restarts.
- rst_n asserted during DATA idx=7 with cmd_valid high → cmd_valid, pdn and done go to 0 asynchronously. After release, the sequence restarts from PDN_LOW.
- VERIFY_EN, master returns 0xFF for read idx 3 → reads continue through idx 20 and STOP is issued. error=1, retry count unchanged.
